// File: rtl/pwm_ramp_ctrl.sv
// Compare-register sequencer for the 200 Hz PWM generator: accepts duty/phase
// commands and ramps the pulse width toward the target, one step per PWM period.
module pwm_ramp_ctrl #(
    parameter int WIDTH  = 16,
    parameter int PERIOD = 10000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             period_tick,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [WIDTH-1:0] cmd_step,
    input  logic [WIDTH-1:0] cmd_phase,
    input  logic             abort,
    output logic [WIDTH-1:0] cr1,
    output logic [WIDTH-1:0] cr2,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] PERIOD_W = WIDTH'(PERIOD);

    typedef enum logic {
        IDLE,
        RAMP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] stp;
    logic [WIDTH-1:0] ph;

    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   cr2_sum;
    logic [WIDTH-1:0] duty_next;
    logic [WIDTH-1:0] cr2_next;

    // Next duty saturates at the target in both directions; sums carry an extra bit
    // so a large step or phase can never wrap before the clamp.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        up_sum    = {1'b0, duty} + {1'b0, stp};
        duty_next = duty;
        if (duty < tgt) begin
            duty_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[WIDTH-1:0];
        end else if (duty > tgt) begin
            duty_next = ((duty - tgt) <= stp) ? tgt : (duty - stp);
        end
        cr2_sum  = {1'b0, ph} + {1'b0, duty_next};
        cr2_next = (cr2_sum >= {1'b0, PERIOD_W}) ? PERIOD_W : cr2_sum[WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            duty      <= '0;
            tgt       <= '0;
            stp       <= '0;
            ph        <= '0;
            cr1       <= '0;
            cr2       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every register sees pre-edge values.
            done <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    tgt       <= (cmd_target > PERIOD_W) ? PERIOD_W : cmd_target;
                    stp       <= (cmd_step == '0) ? WIDTH'(1) : cmd_step;
                    ph        <= (cmd_phase > PERIOD_W) ? PERIOD_W : cmd_phase;
                    state     <= RAMP;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            end else begin
                if (abort) begin
                    // Abort freezes the outputs where they are and takes priority over a tick.
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end else if (period_tick) begin
                    duty <= duty_next;
                    cr1  <= ph;
                    cr2  <= cr2_next;
                    if (duty_next == tgt) begin
                        done      <= 1'b1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: ramps up/down, clamping, saturation,
// abort-with-tick priority and asynchronous reset mid-ramp.
module tb_pwm_ramp_ctrl;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             period_tick;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic [WIDTH-1:0] cmd_step;
    logic [WIDTH-1:0] cmd_phase;
    logic             abort;
    logic [WIDTH-1:0] cr1;
    logic [WIDTH-1:0] cr2;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    pwm_ramp_ctrl #(.WIDTH(WIDTH), .PERIOD(10000)) dut (
        .clock      (clock),
        .reset      (reset),
        .period_tick(period_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_phase  (cmd_phase),
        .abort      (abort),
        .cr1        (cr1),
        .cr2        (cr2),
        .busy       (busy),
        .done       (done)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_cr1, input int e_cr2,
                             input logic e_busy, input logic e_done);
        check({tag, "_cr1"}, 32'(cr1), 32'(e_cr1));
        check({tag, "_cr2"}, 32'(cr2), 32'(e_cr2));
        check({tag, "_busy"}, 32'(busy), 32'(e_busy));
        check({tag, "_done"}, 32'(done), 32'(e_done));
    endtask

    task automatic send(input int t, input int s, input int p);
        @(posedge clock);
        #1;
        cmd_valid  = 1'b1;
        cmd_target = WIDTH'(t);
        cmd_step   = WIDTH'(s);
        cmd_phase  = WIDTH'(p);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("accept_ready", 32'(cmd_ready), 32'd0);
    endtask

    // One PWM wrap every 100 clocks; returns just after the registered update.
    task automatic tick();
        repeat (99) @(posedge clock);
        #1;
        period_tick = 1'b1;
        @(posedge clock);
        #1;
        period_tick = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        period_tick = 1'b0;
        cmd_valid   = 1'b0;
        cmd_target  = '0;
        cmd_step    = '0;
        cmd_phase   = '0;
        abort       = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_out("reset", 0, 0, 1'b0, 1'b0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b1;

        // Ramp up 0 -> 5000 in steps of 1000.
        send(5000, 1000, 0);
        check("up_busy_at_accept", 32'(busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            check("up_hold_cr2", 32'(cr2), 32'(1000 * (k - 1)));
            tick();
            check_out($sformatf("up%0d", k), 0, 1000 * k, (k != 5), (k == 5));
        end
        @(posedge clock);
        #1;
        check("up_done_one_cycle", 32'(done), 32'd0);
        check("up_ready_after", 32'(cmd_ready), 32'd1);

        // Ramp down 5000 -> 2500, last step shortened.
        send(2500, 1000, 0);
        tick(); check_out("dn1", 0, 4000, 1'b1, 1'b0);
        tick(); check_out("dn2", 0, 3000, 1'b1, 1'b0);
        tick(); check_out("dn3", 0, 2500, 1'b0, 1'b1);

        // Back to duty 0, then target/step clamping.
        send(0, 10000, 0);
        tick(); check_out("zero", 0, 0, 1'b0, 1'b1);
        send(12000, 0, 9000);
        tick(); check_out("clamp", 9000, 9001, 1'b1, 1'b0);
        @(posedge clock); #1; abort = 1'b1;
        @(posedge clock); #1; abort = 1'b0;
        check_out("abort_plain", 9000, 9001, 1'b0, 1'b0);
        check("abort_plain_ready", 32'(cmd_ready), 32'd1);

        // cr2 saturates at PERIOD (duty 1 -> 1001 -> 2000, phase 9000).
        send(2000, 1000, 9000);
        tick(); check_out("sat1", 9000, 10000, 1'b1, 1'b0);
        tick(); check_out("sat2", 9000, 10000, 1'b0, 1'b1);

        // Abort together with a tick at duty 3000; held command only accepted afterwards.
        send(5000, 1000, 100);
        tick(); check_out("ab_pre", 100, 3100, 1'b1, 1'b0);
        @(posedge clock); #1;
        cmd_valid  = 1'b1;
        cmd_target = WIDTH'(0);
        cmd_step   = WIDTH'(1000);
        cmd_phase  = WIDTH'(50);
        @(posedge clock); #1;
        check("ab_ignored_ready", 32'(cmd_ready), 32'd0);
        abort       = 1'b1;
        period_tick = 1'b1;
        @(posedge clock); #1;
        abort       = 1'b0;
        period_tick = 1'b0;
        check_out("ab_tick", 100, 3100, 1'b0, 1'b0);
        check("ab_tick_ready", 32'(cmd_ready), 32'd1);
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        check("ab_accept_ready", 32'(cmd_ready), 32'd0);
        check("ab_accept_busy", 32'(busy), 32'd1);
        tick(); check_out("ab_post", 50, 2050, 1'b1, 1'b0);

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #5 reset = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 1'b0, 1'b0);
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clock);
        #3 reset = 1'b1;
        send(0, 5, 700);
        tick(); check_out("zero_tgt", 700, 700, 1'b0, 1'b1);

        // Abort while idle changes nothing.
        @(posedge clock); #1; abort = 1'b1;
        @(posedge clock); #1; abort = 1'b0;
        check_out("idle_abort", 700, 700, 1'b0, 1'b0);
        check("idle_abort_ready", 32'(cmd_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
